// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// piso_pkg : shared types and sizing helpers for the PISO shifter
// Rev 1.0
// ============================================================================
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Counter width for a WIDTH-bit word; holds 0 .. WIDTH-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
// piso_bit_counter : bit index within the word being shifted out
// Rev 1.0
// ============================================================================
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      enable,
  output logic [cnt_w(WIDTH)-1:0]   count,
  output logic                      terminal
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign terminal = (count == LAST);

  // Wraps at the terminal count so the index never exceeds WIDTH-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (terminal) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_shift_register_4bit.sv
`default_nettype none
// ============================================================================
// piso_shift_register_4bit : parallel-in serial-out shifter with load handshake
// Rev 1.0
// ============================================================================
module piso_shift_register_4bit
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             first_bit,
  output logic             last_bit
);

  localparam int CW = cnt_w(WIDTH);

  piso_state_t      state;
  piso_state_t      state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;
  logic [CW-1:0]    bit_cnt;
  logic             at_last;
  logic             shift_step;
  logic             word_done;
  logic             accept;

  assign shift_step = (state == SHIFT) && shift_en;
  assign word_done  = shift_step && at_last;

  // Gated by reset_n so load_ready reads 0 while reset is held.
  assign load_ready = reset_n && ((state == IDLE) || word_done);
  assign accept     = load_valid && load_ready;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .enable   (shift_step),
    .count    (bit_cnt),
    .terminal (at_last)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_bit       = shreg[WIDTH-1];
      assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit       = shreg[0];
      assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= load_data;
    end else if (shift_step) begin
      shreg <= shreg_shifted;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (word_done) begin
          state_next = accept ? SHIFT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    first_bit    = 1'b0;
    last_bit     = 1'b0;
    if (state == SHIFT) begin
      serial_out   = out_bit;
      serial_valid = 1'b1;
      first_bit    = (bit_cnt == '0);
      last_bit     = at_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_register_4bit.sv
`default_nettype none
// ============================================================================
// tb_piso_shift_register_4bit : directed checks of the PISO shifter
// Rev 1.0
// ============================================================================
module tb_piso_shift_register_4bit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] load_data;
  logic       load_valid;
  logic       shift_en;

  logic load_ready, serial_out, serial_valid, first_bit, last_bit;
  logic lsb_load_ready, lsb_serial_out, lsb_serial_valid, lsb_first_bit, lsb_last_bit;

  int total = 0;
  int bad   = 0;

  logic [3:0] sipo;
  logic [7:0] pair;

  piso_shift_register_4bit #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .first_bit    (first_bit),
    .last_bit     (last_bit)
  );

  piso_shift_register_4bit #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (lsb_load_ready),
    .shift_en     (shift_en),
    .serial_out   (lsb_serial_out),
    .serial_valid (lsb_serial_valid),
    .first_bit    (lsb_first_bit),
    .last_bit     (lsb_last_bit)
  );

  always #5 clk = ~clk;

  // Receiving 4-bit SIPO: MSB-first stream shifted in at the LSB end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sipo <= '0;
    end else if (serial_valid && shift_en) begin
      sipo <= {sipo[2:0], serial_out};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_chk(input string tag, input logic b, input logic f,
                         input logic l, input logic r);
    #1;
    chk({tag, ".out"},   32'(serial_out),   32'(b));
    chk({tag, ".valid"}, 32'(serial_valid), 32'd1);
    chk({tag, ".first"}, 32'(first_bit),    32'(f));
    chk({tag, ".last"},  32'(last_bit),     32'(l));
    chk({tag, ".ready"}, 32'(load_ready),   32'(r));
  endtask

  initial begin
    // Reset held with a valid word pending: nothing captured, all outputs 0.
    reset_n    = 1'b0;
    load_data  = 4'b1111;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    repeat (3) tick();
    #1;
    chk("t1.out",       32'(serial_out),     32'd0);
    chk("t1.valid",     32'(serial_valid),   32'd0);
    chk("t1.first",     32'(first_bit),      32'd0);
    chk("t1.last",      32'(last_bit),       32'd0);
    chk("t1.ready",     32'(load_ready),     32'd0);
    chk("t1.lsb_valid", 32'(lsb_serial_valid), 32'd0);
    load_valid = 1'b0;
    reset_n    = 1'b1;
    tick();
    #1;
    chk("t1.post_valid", 32'(serial_valid), 32'd0);
    chk("t1.post_ready", 32'(load_ready),   32'd1);

    // Single word 1011; later load_data changes must not matter.
    load_data  = 4'b1011;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    #1;
    chk("t2.idle_ready", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    load_data  = 4'b0000;
    bit_chk("t2.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5.b1", 32'(lsb_serial_out), 32'd1);
    tick();
    bit_chk("t2.b2", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5.b2", 32'(lsb_serial_out), 32'd1);
    tick();
    bit_chk("t2.b3", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5.b3", 32'(lsb_serial_out), 32'd0);
    tick();
    bit_chk("t2.b4", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5.b4", 32'(lsb_serial_out), 32'd1);
    tick();
    #1;
    chk("t2.end_valid", 32'(serial_valid), 32'd0);
    chk("t2.end_out",   32'(serial_out),   32'd0);
    chk("t6.sipo_1011", 32'(sipo),         32'hB);

    // Back-to-back words with valid held: 8 contiguous bits, no gap.
    pair       = 8'b1011_0100;
    load_data  = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_data = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        load_valid = 1'b0;
      end
      bit_chk($sformatf("t3.b%0d", i + 1), pair[7-i], (i % 4) == 0,
              (i % 4) == 3, (i % 4) == 3);
      if (i == 4) begin
        chk("t6.sipo_first", 32'(sipo), 32'hB);
      end
      tick();
    end
    #1;
    chk("t3.end_valid",  32'(serial_valid), 32'd0);
    chk("t6.sipo_0100",  32'(sipo),         32'h4);

    // Stall three cycles on bit 2; an unready load_valid is ignored.
    load_data  = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    bit_chk("t4.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    shift_en   = 1'b0;
    load_valid = 1'b1;
    load_data  = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      bit_chk($sformatf("t4.stall%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    load_valid = 1'b0;
    shift_en   = 1'b1;
    bit_chk("t4.b2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bit_chk("t4.b3", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bit_chk("t4.b4", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    #1;
    chk("t4.end_valid", 32'(serial_valid), 32'd0);
    chk("t4.sipo",      32'(sipo),         32'hB);

    // Reset pulse after bit 2 aborts the word; next word is clean.
    load_data  = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    bit_chk("t7.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    bit_chk("t7.b2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    chk("t7.rst_out",   32'(serial_out),   32'd0);
    chk("t7.rst_valid", 32'(serial_valid), 32'd0);
    chk("t7.rst_first", 32'(first_bit),    32'd0);
    chk("t7.rst_last",  32'(last_bit),     32'd0);
    chk("t7.rst_ready", 32'(load_ready),   32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("t7.rel_valid", 32'(serial_valid), 32'd0);
    chk("t7.rel_ready", 32'(load_ready),   32'd1);
    load_data  = 4'b0100;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    pair       = 8'b0000_0100;
    for (int i = 0; i < 4; i++) begin
      bit_chk($sformatf("t7.n%0d", i + 1), pair[3-i], i == 0, i == 3, i == 3);
      tick();
    end
    #1;
    chk("t7.end_valid", 32'(serial_valid), 32'd0);
    chk("t7.sipo",      32'(sipo),         32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
